// File: rtl/mips_run_pkg.sv
// Shared types, default parameters and helpers for the MIPS run controller.
package mips_run_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST_HOLD,
    RUN,
    DONE
  } run_state_e;

  localparam int unsigned DEF_RESET_CYCLES = 4;
  localparam int unsigned DEF_MAX_CYCLES   = 1000;
  localparam int unsigned DEF_HALT_REPEAT  = 3;
  localparam int unsigned DEF_CNT_W        = 32;

  // Callers zero-extend into and truncate out of this width.
  localparam int unsigned SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v >= max_v) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/mips_halt_detect.sv
// Halt idiom detector: flags HALT_REPEAT consecutive retires of the same PC.
module mips_halt_detect
  import mips_run_pkg::*;
#(
  parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  output logic        halt
);

  localparam int unsigned     REP_W   = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(HALT_REPEAT);

  logic [31:0]      last_pc_q, last_pc_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    last_pc_d = last_pc_q;
    rep_cnt_d = rep_cnt_q;
    if (clr) begin
      last_pc_d = '0;
      rep_cnt_d = '0;
    end else if (retire_valid) begin
      if (rep_cnt_q != '0 && retire_pc == last_pc_q) begin
        rep_cnt_d = (rep_cnt_q == REP_MAX) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
      end else begin
        rep_cnt_d = REP_W'(1);
        last_pc_d = retire_pc;
      end
    end
  end

  // Flag from the next count so the FSM leaves RUN on the edge of the final retire.
  assign halt = (rep_cnt_d == REP_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: core reset sequencing, cycle/retire counting, halt or budget stop.
// Optional MIPS_RUN_CTRL_STATS_EN adds a saturating bubble_count output.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int unsigned HALT_REPEAT  = DEF_HALT_REPEAT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [31:0]      retire_pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
`ifdef MIPS_RUN_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] bubble_count
`endif
);

  localparam int unsigned      HOLD_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;
  logic              timeout_q, timeout_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              start_ok, hd_valid, halt;
`ifdef MIPS_RUN_CTRL_STATS_EN
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;
`endif

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign hd_valid = retire_valid && (state_q == RUN);

  mips_halt_detect #(
    .HALT_REPEAT(HALT_REPEAT)
  ) u_halt (
    .clk         (clk),
    .reset       (reset),
    .clr         (start_ok),
    .retire_valid(hd_valid),
    .retire_pc   (retire_pc),
    .halt        (halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)               state_d = RST_HOLD;
      RST_HOLD:   if (hold_q == HOLD_LAST) state_d = RUN;
      RUN:        if (halt || cycle_count_q == CYC_LAST) state_d = DONE;
      default:                             state_d = IDLE;
    endcase
  end

  // Outputs decoded from next state and registered below.
  always_comb begin
    cpu_reset_d = (state_d != RUN);
    running_d   = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  always_comb begin
    hold_d         = '0;
    cycle_count_d  = cycle_count_q;
    retire_count_d = retire_count_q;
    timeout_d      = timeout_q;
`ifdef MIPS_RUN_CTRL_STATS_EN
    bubble_count_d = bubble_count_q;
`endif
    if (state_q == RST_HOLD) hold_d = hold_q + HOLD_W'(1);
    if (start_ok) begin
      cycle_count_d  = '0;
      retire_count_d = '0;
      timeout_d      = 1'b0;
`ifdef MIPS_RUN_CTRL_STATS_EN
      bubble_count_d = '0;
`endif
    end else if (state_q == RUN) begin
      cycle_count_d = CNT_W'(sat_inc(SAT_W'(cycle_count_q), SAT_W'(CNT_MAX)));
      if (retire_valid)
        retire_count_d = CNT_W'(sat_inc(SAT_W'(retire_count_q), SAT_W'(CNT_MAX)));
`ifdef MIPS_RUN_CTRL_STATS_EN
      else
        bubble_count_d = CNT_W'(sat_inc(SAT_W'(bubble_count_q), SAT_W'(CNT_MAX)));
`endif
      // Halt takes priority over a simultaneous budget expiry.
      if (state_d == DONE) timeout_d = !halt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q         <= '0;
      cycle_count_q  <= '0;
      retire_count_q <= '0;
      timeout_q      <= 1'b0;
      cpu_reset_q    <= 1'b1;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
`ifdef MIPS_RUN_CTRL_STATS_EN
      bubble_count_q <= '0;
`endif
    end else begin
      hold_q         <= hold_d;
      cycle_count_q  <= cycle_count_d;
      retire_count_q <= retire_count_d;
      timeout_q      <= timeout_d;
      cpu_reset_q    <= cpu_reset_d;
      running_q      <= running_d;
      done_q         <= done_d;
`ifdef MIPS_RUN_CTRL_STATS_EN
      bubble_count_q <= bubble_count_d;
`endif
    end
  end

  assign cpu_reset    = cpu_reset_q;
  assign running      = running_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cycle_count_q;
  assign retire_count = retire_count_q;
`ifdef MIPS_RUN_CTRL_STATS_EN
  assign bubble_count = bubble_count_q;
`endif

endmodule
